// File: rtl/riscv_pkg.sv
// Shared hart definitions: data width, instruction alignment and the fetch packet
// that travels from fetch to decode.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [1:0] INST_ALIGN_MASK = 2'b11;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            fault;
    } fetch_pkt_t;

    localparam int FETCH_PKT_W = $bits(fetch_pkt_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush, occupancy count and push/pop in the
// same cycle at any occupancy, including full.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty & ~flush;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop) & ~flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: request/response imem interface, up to DEPTH words in
// flight or buffered, redirect flush with stale-response squashing. Same-cycle
// response bypass to decode is enabled by defining FETCH_BYPASS_EN.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000,
    parameter int              DEPTH      = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc,
    output logic            o_fault,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic            halted;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_push;
    logic            fifo_pop;
    fetch_pkt_t      push_pkt;
    fetch_pkt_t      head_pkt;

    logic [CW:0]     occupancy;
    logic            misaligned;
    logic            issue;
    logic            rsp_keep;
    logic            fault_push;
    logic            bypass;
    logic            bypass_take;

    // fetch_pc only goes misaligned through a redirect; it then parks until the next one
    assign misaligned = (fetch_pc[1:0] & INST_ALIGN_MASK) != 2'b00;
    assign occupancy  = {1'b0, fifo_count} + {1'b0, outstanding};

    assign o_imem_req  = i_rst_n & ~halted & ~i_redirect & ~misaligned & (occupancy < DEPTH_LIM);
    assign o_imem_addr = fetch_pc;
    assign issue       = o_imem_req & i_imem_gnt;

    assign rsp_keep   = i_imem_rvalid & (discard == '0) & ~i_redirect;
    assign fault_push = misaligned & ~halted & (discard == '0) & (outstanding == '0)
                        & ~i_redirect & ~fifo_full & ~rsp_keep;

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_keep & fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign bypass_take = bypass & i_ready;
    assign fifo_push   = (rsp_keep & ~bypass_take) | fault_push;
    assign fifo_pop    = ~fifo_empty & ~i_redirect & i_ready;

    always_comb begin
        push_pkt.pc    = resp_pc;
        push_pkt.inst  = i_imem_rdata;
        push_pkt.fault = 1'b0;
        if (!rsp_keep) begin
            push_pkt.inst  = '0;
            push_pkt.fault = 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FETCH_PKT_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .flush (i_redirect),
        .push  (fifo_push),
        .wdata (push_pkt),
        .pop   (fifo_pop),
        .rdata (head_pkt),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        o_valid = 1'b0;
        o_inst  = '0;
        o_pc    = '0;
        o_fault = 1'b0;
        if (!fifo_empty && !i_redirect) begin
            o_valid = 1'b1;
            o_inst  = head_pkt.inst;
            o_pc    = head_pkt.pc;
            o_fault = head_pkt.fault;
        end else if (bypass) begin
            o_valid = 1'b1;
            o_inst  = i_imem_rdata;
            o_pc    = resp_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc    <= RESET_ADDR;
            resp_pc     <= RESET_ADDR;
            outstanding <= '0;
            discard     <= '0;
            halted      <= 1'b0;
        end else if (i_redirect) begin
            // everything still in flight belongs to the old stream
            fetch_pc    <= i_redirect_pc;
            resp_pc     <= i_redirect_pc;
            outstanding <= outstanding - CW'(i_imem_rvalid);
            discard     <= outstanding - CW'(i_imem_rvalid);
            halted      <= 1'b0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_keep) begin
                resp_pc <= resp_pc + 32'd4;
            end
            if (i_imem_rvalid && discard != '0) begin
                discard <= discard - 1'b1;
            end
            outstanding <= outstanding + CW'(issue) - CW'(i_imem_rvalid);
            if (fault_push) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order variable-latency memory model, packet
// log toward decode, hand-computed PC/instruction sequences after each event.
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
    localparam int EXP_LAT = 1;
    localparam int EXP_BYP = 0;
`else
    localparam int EXP_LAT = 2;
    localparam int EXP_BYP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        valid;
    logic        ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_ADDR (32'h0000_0000),
        .DEPTH      (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_inst        (inst),
        .o_pc          (pc),
        .o_fault       (fault),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
        int          cyc;
    } rx_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mq_t;

    rx_t  rx[$];
    mq_t  mq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lat = 1;
    int   n_req = 0;
    int   first_issue = -1;
    int   rv_cyc = -1;
    int   b = 0;
    int   pre_n = 0;
    logic no_req_expected = 1'b0;
    logic last_valid = 1'b0;
    logic last_req = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pkt(input string tag, input int idx, input logic [31:0] exp_pc,
                             input logic [31:0] exp_inst, input logic exp_fault);
        check({tag, "_present"}, 32'(rx.size() > idx), 32'd1);
        if (rx.size() > idx) begin
            check({tag, "_pc"}, rx[idx].pc, exp_pc);
            check({tag, "_inst"}, rx[idx].inst, exp_inst);
            check({tag, "_fault"}, {31'd0, rx[idx].fault}, {31'd0, exp_fault});
        end
    endtask

    // one cycle: sample at the falling edge, then present the memory response for the next cycle
    task automatic step();
        @(negedge clk);
        last_valid = valid;
        last_req   = req;
        if (req && gnt) begin
            mq.push_back('{addr: addr, due: cyc + lat});
            n_req++;
            if (first_issue < 0) first_issue = cyc;
        end
        if (valid && ready) rx.push_back('{pc: pc, inst: inst, fault: fault, cyc: cyc});
        if (!valid) begin
            check("idle_inst", inst, 32'h0);
            check("idle_pc", pc, 32'h0);
        end
        if (req) check("req_align", {30'd0, addr[1:0]}, 32'h0);
        if (no_req_expected) check("no_req", {31'd0, req}, 32'h0);
        @(posedge clk);
        #1;
        cyc++;
        rvalid = 1'b0;
        rdata  = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = word_of(mq[0].addr);
            rv_cyc = cyc;
            void'(mq.pop_front());
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        gnt = 1'b0; ready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_req", {31'd0, req}, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_fault", {31'd0, fault}, 32'h0);
        check("rst_addr", addr, 32'h0);

        // streaming from reset, latency 1
        gnt = 1'b1; ready = 1'b1; lat = 1; rst_n = 1'b1;
        first_issue = -1;
        b = rx.size();
        run(12);
        for (int i = 0; i < 8; i++) begin
            check_pkt($sformatf("seq%0d", i), b + i, 32'(4 * i), word_of(32'(4 * i)), 1'b0);
            if (rx.size() > b + i) check($sformatf("seq%0d_cyc", i), 32'(rx[b + i].cyc - rx[b].cyc), 32'(i));
        end
        if (rx.size() > b) check("first_lat", 32'(rx[b].cyc - first_issue), 32'(EXP_LAT));

        // decode stalled: exactly DEPTH requests, then resume without loss or duplication
        ready = 1'b0;
        b = rx.size();
        do_redirect(32'h40);
        n_req = 0;
        run(10);
        check("stall_reqs", 32'(n_req), 32'd4);
        check("stall_req_low", {31'd0, last_req}, 32'h0);
        check("stall_rx", 32'(rx.size() - b), 32'd0);
        ready = 1'b1;
        run(14);
        for (int i = 0; i < 10; i++) begin
            check_pkt($sformatf("resume%0d", i), b + i, 32'h40 + 32'(4 * i), word_of(32'h40 + 32'(4 * i)), 1'b0);
        end

        // three in flight at latency 3, redirect lands with the first response
        gnt = 1'b0; lat = 3;
        do_redirect(32'h80);
        run(6);
        b = rx.size();
        n_req = 0;
        gnt = 1'b1;
        run(3);
        gnt = 1'b0;
        check("lat3_issued", 32'(n_req), 32'd3);
        do_redirect(32'h100);
        gnt = 1'b1;
        run(15);
        check_pkt("redir_first", b, 32'h100, word_of(32'h100), 1'b0);
        check_pkt("redir_second", b + 1, 32'h104, word_of(32'h104), 1'b0);

        // misaligned target: no requests, a single fault packet, then idle
        no_req_expected = 1'b1;
        b = rx.size();
        do_redirect(32'h102);
        n_req = 0;
        run(12);
        check("misal_reqs", 32'(n_req), 32'd0);
        check("misal_rx", 32'(rx.size() - b), 32'd1);
        check_pkt("misal_pkt", b, 32'h102, 32'h0, 1'b1);
        no_req_expected = 1'b0;

        // restart at 0x200 with latency 2, then redirect amid rvalid + pop with 2 outstanding
        lat = 2;
        b = rx.size();
        do_redirect(32'h200);
        run(10);
        for (int i = 0; i < 5; i++) begin
            check_pkt($sformatf("l2_%0d", i), b + i, 32'h200 + 32'(4 * i), word_of(32'h200 + 32'(4 * i)), 1'b0);
        end
        pre_n = rx.size();
        do_redirect(32'h300);
        check("redir_valid", {31'd0, last_valid}, 32'h0);
        check("redir_no_pop", 32'(rx.size()), 32'(pre_n));
        run(10);
        check_pkt("squash_first", pre_n, 32'h300, word_of(32'h300), 1'b0);
        check_pkt("squash_second", pre_n + 1, 32'h304, word_of(32'h304), 1'b0);

        // PC wraps past the top of the address space
        lat = 1;
        b = rx.size();
        do_redirect(32'hFFFF_FFF8);
        run(10);
        check_pkt("wrap0", b, 32'hFFFF_FFF8, word_of(32'hFFFF_FFF8), 1'b0);
        check_pkt("wrap1", b + 1, 32'hFFFF_FFFC, word_of(32'hFFFF_FFFC), 1'b0);
        check_pkt("wrap2", b + 2, 32'h0, word_of(32'h0), 1'b0);
        check_pkt("wrap3", b + 3, 32'h4, word_of(32'h4), 1'b0);

        // single response into an empty FIFO: rvalid-to-valid latency
        gnt = 1'b0;
        do_redirect(32'h400);
        run(6);
        b = rx.size();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        run(5);
        check("single_rx", 32'(rx.size() - b), 32'd1);
        check_pkt("single_pkt", b, 32'h400, word_of(32'h400), 1'b0);
        if (rx.size() > b) check("bypass_lat", 32'(rx[b].cyc - rv_cyc), 32'(EXP_BYP));

        // asynchronous reset mid-stream
        gnt = 1'b1;
        run(5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, req}, 32'h0);
        check("mid_rst_valid", {31'd0, valid}, 32'h0);
        check("mid_rst_addr", addr, 32'h0);
        check("mid_rst_pc", pc, 32'h0);
        mq.delete();
        rvalid = 1'b0;
        rdata  = 32'h0;
        @(posedge clk);
        #1;
        b = rx.size();
        rst_n = 1'b1;
        run(8);
        check_pkt("post_rst0", b, 32'h0, word_of(32'h0), 1'b0);
        check_pkt("post_rst1", b + 1, 32'h4, word_of(32'h4), 1'b0);
        check_pkt("post_rst2", b + 2, 32'h8, word_of(32'h8), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
